uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entries; a power of two, 2 to 64.
REQ-002 The block SHALL have parameter AW, default 3, FIFO pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_valid  input  1  store to the UART data address this cycle (from the memory-map decode, already stall-qualified).
REQ-006 The block SHALL have port wr_data  input  8  byte to transmit.
REQ-007 The block SHALL have port stall_req  output  1  pipeline stall request.
REQ-008 The block SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-009 The block SHALL have port tx_valid  output  1  tx_data is valid.
REQ-010 The block SHALL have port tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-011 The block SHALL have port tx_idle  output  1  FIFO empty and output register empty.
REQ-012 The block SHALL have port level  output  AW+1  FIFO occupancy.

Function
REQ-013 The block SHALL contain a DEPTH-entry byte FIFO (wr_ptr, rd_ptr, count) feeding a one-entry output register (tx_data, tx_valid).
REQ-014 The output register SHALL run a two-state FSM: EMPTY (tx_valid=0) and HOLD (tx_valid=1).
REQ-015 In EMPTY with count>0, the head SHALL be popped and loaded; next state HOLD.
REQ-016 In HOLD, tx_data SHALL stay stable until tx_valid&tx_ready.
REQ-017 On tx_valid&tx_ready: with count>0 the head is popped and loaded, state stays HOLD (back-to-back, no bubble); with count=0 next state is EMPTY.
REQ-018 Latency: a push into an empty block at cycle N SHALL produce tx_valid=1 with that byte at cycle N+2 (write N, load N+1, visible N+2 registered); no combinational path from wr_* to tx_*.
REQ-019 A push SHALL be accepted when wr_valid=1 and count<DEPTH.
REQ-020 stall_req SHALL be combinational: wr_valid & (count==DEPTH); full is evaluated before any same-cycle pop, so a write to a full FIFO stalls even while a pop happens.
REQ-021 A stalled write SHALL NOT be stored; the pipeline re-presents it, and it is accepted on the first cycle count<DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0; byte order is strictly FIFO.
REQ-024 count SHALL never exceed DEPTH nor underflow; pop only when count>0.
REQ-025 tx_idle SHALL be (count==0) & ~tx_valid.

Reset
REQ-026 While rst=1 at a clock edge: count, wr_ptr, rd_ptr = 0; tx_valid = 0; tx_data = 8'h00; FSM = EMPTY; FIFO contents are not cleared.
REQ-027 Reset mid-operation SHALL discard all queued and held bytes; tx_valid is 0 in the cycle after the reset edge, and stall_req then follows REQ-020 with count=0, which gives 0.

Configuration
REQ-028 With macro UART_TX_LEVEL_EN defined, level SHALL equal count, registered, with the same timing as count.
REQ-029 Without UART_TX_LEVEL_EN, level SHALL be tied to 0 and no extra logic SHALL be inferred; all other behaviour is identical.

Verification
REQ-030 Single byte: reset, tx_ready=1, push 8'hA5 at cycle N -> tx_valid=1, tx_data=8'hA5 at N+2, tx_idle=1 at N+3.
REQ-031 Fill and stall: tx_ready=0, push 8'h01..8'h09 on consecutive cycles -> level peaks at 8 (macro on); stall_req=1 on the 10th attempted push (8'h0A) only, and 8'h0A is not stored.
REQ-032 Drain order: from the REQ-031 state, hold wr_valid with 8'h0A and raise tx_ready -> bytes 01,02,…,0A are emitted in order, one per cycle with no bubbles, and stall_req drops the cycle after the first pop.
REQ-033 Backpressure: tx_ready toggles 1,0,1,0 with 4 queued bytes -> tx_data is stable while tx_ready=0, and each byte is emitted exactly once.
REQ-034 Reset mid-stream: 5 bytes queued, assert rst for 1 cycle -> tx_valid=0, level=0, and tx_idle=1 in the next cycle; a following push of 8'h3C is emitted as the first byte.
REQ-035 Wrap: push and drain 20 bytes with DEPTH=8 -> pointers wrap twice and the output sequence matches the input.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte FIFO in front of a one-entry output register that
// feeds a UART transmitter. Store requests arrive already qualified from the
// memory-map decode; a store to a full FIFO raises stall_req so the pipeline
// re-presents it later.
// Optional feature macro: UART_TX_LEVEL_EN exposes FIFO occupancy on 'level'.
// Without it, 'level' is tied to zero.
module uart_tx_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [7:0]    wr_data,
  output logic          stall_req,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_idle,
  output logic [AW:0]   level
);

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } txState_t;

  txState_t        r_state;
  txState_t        w_stateNext;

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [AW:0]     r_count;
  logic [7:0]      r_txData;

  logic            w_full;
  logic            w_notEmpty;
  logic            w_push;
  logic            w_pop;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // frees a slot for the write that is presented in that cycle.
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_notEmpty = (r_count != '0);
  assign w_push     = wr_valid & ~w_full;

  assign stall_req  = wr_valid & w_full;
  assign tx_valid   = (r_state == HOLD);
  assign tx_data    = r_txData;
  assign tx_idle    = ~w_notEmpty & ~tx_valid;

`ifdef UART_TX_LEVEL_EN
  assign level = r_count;
`else
  assign level = '0;
`endif

  // Output register control: load the FIFO head whenever the register is
  // empty or its current byte is being taken, giving back-to-back transfers.
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_notEmpty) begin
          w_pop       = 1'b1;
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          if (w_notEmpty) begin
            w_pop = 1'b1;
          end else begin
            w_stateNext = EMPTY;
          end
        end
      end
      default: begin
        w_stateNext = EMPTY;
      end
    endcase
  end

  // State register for the output-register FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Output byte register: only changes when a new head is loaded, so the
  // byte stays stable while the transmitter is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txData <= 8'h00;
    end else if (w_pop) begin
      r_txData <= r_mem[r_rdPtr];
    end
  end

  // FIFO storage is deliberately left uninitialised on reset; the pointers
  // and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap
  // naturally at DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
